// File: rtl/adder_pkg.sv
// Shared types and sizing constants for the bit-serial adder.
package adder_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder composed from library gates: sum = a^b^cin, cout = ab | cin(a^b).
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;
  logic g;
  logic t;

  xor2 u_xor_p   (.a(a),   .b(b),   .y(p));
  xor2 u_xor_s   (.a(p),   .b(cin), .y(sum));
  and2 u_and_g   (.a(a),   .b(b),   .y(g));
  and2 u_and_t   (.a(p),   .b(cin), .y(t));
  or2  u_or_cout (.a(g),   .b(t),   .y(cout));

endmodule

// File: rtl/gate_lib.sv
// Two-input combinational gate primitives used to build arithmetic slices.
module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/serial_adder16.sv
// Bit-serial adder: one full-adder slice processes the operands LSB first,
// one bit per clock, with a start/busy/done handshake.
module serial_adder16
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;
  logic             last;
  logic             accept;
  logic             busy_next;
  logic             done_next;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .sum  (s_bit),
    .cout (c_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a new operation is accepted from IDLE or the DONE cycle
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, publish at the MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      c    <= cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc  <= {s_bit, acc[WIDTH-1:1]};
      c    <= c_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum  <= {s_bit, acc[WIDTH-1:1]};
        cout <= c_next;
        ovf  <= c ^ c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder16.sv
// Randomized scoreboard bench for serial_adder16 against an arithmetic reference model.
module tb_serial_adder16;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests  = 0;
  int errors = 0;

  res_t         sb[$];
  res_t         pend;
  int unsigned  run_left = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  bit           chk_en = 1'b0;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t         r;
    logic [W:0]   t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Reference model: an accepted add takes W cycles, then results show for one done cycle
  always @(posedge clk) begin
    if (reset) begin
      run_left = 0;
      m_done   = 1'b0;
      m_sum    = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
      sb.delete();
      chk_en   = 1'b1;
    end else if (run_left > 0) begin
      run_left = run_left - 1;
      if (run_left == 0) begin
        m_sum  = pend.sum;
        m_cout = pend.cout;
        m_ovf  = pend.ovf;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        pend = ref_add(a, b, cin);
        sb.push_back(pend);
        run_left = W;
      end
    end
    m_busy = (run_left > 0);
  end

  // Monitor: cycle-by-cycle protocol/hold check plus scoreboard pop on each done
  always @(negedge clk) begin
    res_t r;
    if (chk_en) begin
      tests++;
      if ({busy, done, sum, cout, ovf} !== {m_busy, m_done, m_sum, m_cout, m_ovf}) begin
        errors++;
        $display("FAIL cycle t=%0t: busy=%b done=%b sum=%h cout=%b ovf=%b, required busy=%b done=%b sum=%h cout=%b ovf=%b",
                 $time, busy, done, sum, cout, ovf, m_busy, m_done, m_sum, m_cout, m_ovf);
      end
      if (done === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty t=%0t: done with no outstanding operation", $time);
        end else begin
          r = sb.pop_front();
          if ({sum, cout, ovf} !== {r.sum, r.cout, r.ovf}) begin
            errors++;
            $display("FAIL result t=%0t: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     $time, sum, cout, ovf, r.sum, r.cout, r.ovf);
          end
        end
      end
    end
  end

  // Directed operation checked against fixed expected constants in its done cycle
  task automatic run_check(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    tests++;
    if ({done, sum, cout, ovf} !== {1'b1, es, ec, eo}) begin
      errors++;
      $display("FAIL directed %h+%h+%b: done=%b sum=%h cout=%b ovf=%b, required done=1 sum=%h cout=%b ovf=%b",
               ta, tb_, tc, done, sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk);
  endtask

  initial begin
    int gap;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0", busy, done, sum, cout, ovf);
    end

    run_check(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_check(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_check(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_check(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);

    // start held high: mid-run starts ignored, new op accepted in each done cycle
    start = 1'b1;
    repeat (4 * (W + 1) + 2) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Reset mid-run aborts; then a fresh start completes normally
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0", busy, done, sum, cout, ovf);
    end
    run_check(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Reset and start together: reset wins
    reset = 1'b1; start = 1'b1; a = 16'h00FF; b = 16'h0F0F; cin = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Random regression with idle gaps of 0..2 (0 exercises back-to-back from DONE)
    for (int n = 0; n < 1000; n++) begin
      start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      gap = int'($urandom_range(0, 2));
      repeat (W + gap) @(negedge clk);
    end
    repeat (W + 3) @(negedge clk);

    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d operations never completed, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
